regfile_multiport: RTL and testbench
====================================

Name: regfile_multiport

Overview:
- Parametrised, clocked general-purpose register file for the decode stage.
- Provides NUM_RD combinational read ports and one write-back port, with optional write-to-read bypass and an optional hard-wired zero register.
- A bank of exception shadow registers (rm) captures the faulting PC and address when the MEM/WB stage raises an exception.
- A sticky handshake flag lets the trap handler consume the captured exception state; read port 0 can be steered to any rm entry.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (>=1).
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes.
- BYPASS, 1, when 1, a read of the register being written this cycle returns wr_data.
- NUM_RM, 2, number of exception shadow registers (>=2); rm[0]=PC, rm[1]=faulting address, others reserved (read 0).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data.
- move_rm  in  1  steers read port 0 to rm[rm_sel].
- rm_sel  in  clog2(NUM_RM)  shadow register index for port 0.
- wr_en  in  1  write-back enable (mem_wb.regWrite).
- wr_addr  in  ADDR_W  write-back register (mem_wb.rd).
- wr_data  in  DATA_W  write-back value (wb.valueToWB).
- exc_valid  in  1  exception in MEM/WB this cycle.
- exc_pc  in  DATA_W  PC of faulting instruction.
- exc_addr  in  DATA_W  faulting address.
- rm_ack  in  1  handler has consumed the shadow state.
- rm_valid  out  1  shadow registers hold an unconsumed exception.
- rm_overflow  out  1  sticky: an exception arrived while rm_valid=1.

Behaviour:
- Reset (async, immediate): all 2**ADDR_W registers = 0; all rm = 0; rm_valid = 0; rm_overflow = 0. Reads during reset return 0.
- Write: on posedge clk with wr_en=1 and exc_valid=0, registers[wr_addr] <= wr_data. Write latency is 1 cycle; the value is visible on a non-bypassed read the cycle after.
- Zero register: with ZERO_REG=1, writes to address 0 are dropped and reads of address 0 return 0. Address 0 is never bypassed.
- Exception priority: exc_valid=1 suppresses that cycle's register write, regardless of wr_en.
- Read (combinational), per port i:
  - Port 0 with move_rm=1: rm[rm_sel]; rm_sel >= NUM_RM returns 0.
  - Otherwise, if BYPASS=1, wr_en=1, exc_valid=0, wr_addr==rd_addr[i] and the address is not zero-protected: wr_data.
  - Otherwise: registers[rd_addr[i]].
- Exception capture and handshake, as a 2-state FSM:
  - IDLE (rm_valid=0): exc_valid=1 at posedge -> rm[0]<=exc_pc, rm[1]<=exc_addr, go to HELD. rm_ack is ignored in IDLE.
  - HELD (rm_valid=1): rm_ack=1 with exc_valid=0 -> go to IDLE; rm contents are retained.
  - HELD with exc_valid=1 -> rm_overflow<=1; rm is overwritten with the new values and the FSM stays in HELD, even if rm_ack=1 in the same cycle (the newest exception wins).
- rm_overflow clears only on reset.
- Reset asserted mid-operation (during HELD, or with a write pending) -> everything returns to reset values immediately; no partial write survives.
- Multiple read ports addressing the same register all return identical data.
- No internal file I/O.

Test Plan:
- Reset then read: assert reset, write 0xDEADBEEF to r5 while reset is held -> rd_data on all ports = 0; after release, read r5 = 0.
- Write and bypass: BYPASS=1, cycle N wr_en=1, wr_addr=7, wr_data=0x12345678, rd_addr port1=7 -> port1 = 0x12345678 in cycle N; rebuild with BYPASS=0 -> port1 = 0 in cycle N and 0x12345678 in N+1.
- Zero register: write 0xFFFFFFFF to r0 -> all ports reading r0 return 0, including in the write cycle.
- Exception priority: wr_en=1 to r3 with 0xAA and exc_valid=1, exc_pc=0x400, exc_addr=0x1000 in the same cycle -> r3 unchanged (0), rm[0]=0x400, rm[1]=0x1000, rm_valid=1; move_rm=1, rm_sel=1 -> port0 = 0x1000.
- Overflow and ack: in HELD, second exc_valid with exc_pc=0x500 -> rm[0]=0x500, rm_overflow=1, rm_valid stays 1; then rm_ack=1 -> rm_valid=0, rm_overflow still 1, rm[0] still 0x500.
- Multiport: NUM_RD=4, all ports reading distinct written registers r1..r4 (values 1..4) -> each port returns its own value; mid-sequence async reset -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport: decode-stage general-purpose register file.
// NUM_RD combinational read ports, one write-back port, optional
// write-to-read bypass, optional hard-wired zero register, and a small
// bank of exception shadow registers with a sticky consume handshake.
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int NUM_RM   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*ADDR_W-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0]     rd_data,
  input  logic                         move_rm,
  input  logic [$clog2(NUM_RM)-1:0]    rm_sel,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         exc_valid,
  input  logic [DATA_W-1:0]            exc_pc,
  input  logic [DATA_W-1:0]            exc_addr,
  input  logic                         rm_ack,
  output logic                         rm_valid,
  output logic                         rm_overflow
);

  localparam int DEPTH    = 2 ** ADDR_W;
  localparam int RM_SEL_W = $clog2(NUM_RM);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } rmState_t;

  rmState_t          rmState;
  logic [DATA_W-1:0] regFile [DEPTH];
  logic [DATA_W-1:0] rmPc;
  logic [DATA_W-1:0] rmAddr;
  logic [DATA_W-1:0] rmRead;
  logic              rmValidReg;
  logic              rmOverflowReg;
  logic              writeZeroProt;
  logic              writeFire;

  // A write lands only when no exception is in MEM/WB and the target is
  // not the protected zero register.
  assign writeZeroProt = (ZERO_REG != 0) && (wr_addr == '0);
  assign writeFire     = wr_en && !exc_valid && !writeZeroProt;

  // Register storage: every entry clears on reset so reads start at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile[i] <= '0;
      end
    end else if (writeFire) begin
      regFile[wr_addr] <= wr_data;
    end
  end

  // Exception capture FSM: newest exception always overwrites the shadow
  // state; a capture while still HELD marks overflow, which stays set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rmState       <= IDLE;
      rmPc          <= '0;
      rmAddr        <= '0;
      rmValidReg    <= 1'b0;
      rmOverflowReg <= 1'b0;
    end else begin
      case (rmState)
        IDLE: begin
          if (exc_valid) begin
            rmPc       <= exc_pc;
            rmAddr     <= exc_addr;
            rmState    <= HELD;
            rmValidReg <= 1'b1;
          end
        end
        HELD: begin
          if (exc_valid) begin
            rmPc          <= exc_pc;
            rmAddr        <= exc_addr;
            rmOverflowReg <= 1'b1;
          end else if (rm_ack) begin
            rmState    <= IDLE;
            rmValidReg <= 1'b0;
          end
        end
        default: begin
          rmState    <= IDLE;
          rmValidReg <= 1'b0;
        end
      endcase
    end
  end

  assign rm_valid    = rmValidReg;
  assign rm_overflow = rmOverflowReg;

  // Shadow register read mux; indices beyond PC/address are reserved zeros.
  always_comb begin
    rmRead = '0;
    if (rm_sel == RM_SEL_W'(0)) begin
      rmRead = rmPc;
    end else if (rm_sel == RM_SEL_W'(1)) begin
      rmRead = rmAddr;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : gRead
      logic [ADDR_W-1:0] portAddr;
      logic [DATA_W-1:0] portData;
      logic              zeroProt;
      logic              bypassHit;
      logic              useRm;

      assign portAddr  = rd_addr[gi*ADDR_W +: ADDR_W];
      assign zeroProt  = (ZERO_REG != 0) && (portAddr == '0);
      assign bypassHit = (BYPASS != 0) && wr_en && !exc_valid &&
                         (wr_addr == portAddr) && !zeroProt;
      assign useRm     = (gi == 0) ? move_rm : 1'b0;

      // Per-port read: reset forces zero so a bypassed write can't leak out.
      always_comb begin
        portData = '0;
        if (reset) begin
          portData = '0;
        end else if (useRm) begin
          portData = rmRead;
        end else if (bypassHit) begin
          portData = wr_data;
        end else if (zeroProt) begin
          portData = '0;
        end else begin
          portData = regFile[portAddr];
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = portData;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed testbench for regfile_multiport.
// dut  : NUM_RD=4, BYPASS=1, ZERO_REG=1, NUM_RM=2
// dut2 : NUM_RD=2, BYPASS=0, ZERO_REG=0, NUM_RM=4
module tb_regfile_multiport;

  logic         clk;
  logic         reset;
  logic [19:0]  rdAddr;
  logic [127:0] rdData;
  logic [9:0]   rdAddr2;
  logic [63:0]  rdData2;
  logic         moveRm;
  logic [0:0]   rmSel;
  logic [1:0]   rmSel2;
  logic         wrEn;
  logic [4:0]   wrAddr;
  logic [31:0]  wrData;
  logic         excValid;
  logic [31:0]  excPc;
  logic [31:0]  excAddr;
  logic         rmAck;
  logic         rmValid;
  logic         rmOverflow;
  logic         rmValid2;
  logic         rmOverflow2;

  int errors;
  int checks;

  regfile_multiport #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1), .NUM_RM(2)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rdAddr), .rd_data(rdData),
    .move_rm(moveRm), .rm_sel(rmSel), .wr_en(wrEn), .wr_addr(wrAddr),
    .wr_data(wrData), .exc_valid(excValid), .exc_pc(excPc),
    .exc_addr(excAddr), .rm_ack(rmAck), .rm_valid(rmValid),
    .rm_overflow(rmOverflow)
  );

  regfile_multiport #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0), .NUM_RM(4)
  ) dut2 (
    .clk(clk), .reset(reset), .rd_addr(rdAddr2), .rd_data(rdData2),
    .move_rm(moveRm), .rm_sel(rmSel2), .wr_en(wrEn), .wr_addr(wrAddr),
    .wr_data(wrData), .exc_valid(excValid), .exc_pc(excPc),
    .exc_addr(excAddr), .rm_ack(rmAck), .rm_valid(rmValid2),
    .rm_overflow(rmOverflow2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] p1(input int i);
    return rdData[i*32 +: 32];
  endfunction

  function automatic logic [31:0] p2(input int i);
    return rdData2[i*32 +: 32];
  endfunction

  task automatic set_all_addr(input logic [4:0] a);
    for (int i = 0; i < 4; i++) rdAddr[i*5 +: 5] = a;
    for (int i = 0; i < 2; i++) rdAddr2[i*5 +: 5] = a;
  endtask

  task automatic test_reset;
    reset = 1'b1; wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'hDEADBEEF;
    excValid = 1'b0; excPc = '0; excAddr = '0; rmAck = 1'b0;
    moveRm = 1'b0; rmSel = '0; rmSel2 = '0;
    set_all_addr(5'd5);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p1(i) !== 32'h0) begin
        errors++; $display("FAIL reset_read_p%0d: got %h expected %h", i, p1(i), 32'h0);
      end
    end
    checks++;
    if (rmValid !== 1'b0) begin
      errors++; $display("FAIL reset_rm_valid: got %b expected 0", rmValid);
    end
    checks++;
    if (rmOverflow !== 1'b0) begin
      errors++; $display("FAIL reset_rm_overflow: got %b expected 0", rmOverflow);
    end
    @(negedge clk);
    reset = 1'b0; wrEn = 1'b0;
    #1;
    checks++;
    if (p1(0) !== 32'h0) begin
      errors++; $display("FAIL reset_r5_after: got %h expected %h", p1(0), 32'h0);
    end
    checks++;
    if (p2(0) !== 32'h0) begin
      errors++; $display("FAIL reset_r5_after_nobypass: got %h expected %h", p2(0), 32'h0);
    end
    $display("test_reset: done");
  endtask

  task automatic test_write_bypass;
    @(negedge clk);
    wrEn = 1'b1; wrAddr = 5'd7; wrData = 32'h12345678;
    rdAddr[5 +: 5] = 5'd7; rdAddr2[5 +: 5] = 5'd7;
    #1;
    checks++;
    if (p1(1) !== 32'h12345678) begin
      errors++; $display("FAIL bypass_same_cycle: got %h expected %h", p1(1), 32'h12345678);
    end
    checks++;
    if (p2(1) !== 32'h0) begin
      errors++; $display("FAIL nobypass_same_cycle: got %h expected %h", p2(1), 32'h0);
    end
    @(posedge clk); #1;
    wrEn = 1'b0;
    #1;
    checks++;
    if (p2(1) !== 32'h12345678) begin
      errors++; $display("FAIL nobypass_next_cycle: got %h expected %h", p2(1), 32'h12345678);
    end
    checks++;
    if (p1(1) !== 32'h12345678) begin
      errors++; $display("FAIL bypass_next_cycle: got %h expected %h", p1(1), 32'h12345678);
    end
    $display("test_write_bypass: done");
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    set_all_addr(5'd0);
    wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFFFFFF;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p1(i) !== 32'h0) begin
        errors++; $display("FAIL zero_write_cycle_p%0d: got %h expected %h", i, p1(i), 32'h0);
      end
    end
    @(posedge clk); #1;
    wrEn = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p1(i) !== 32'h0) begin
        errors++; $display("FAIL zero_after_p%0d: got %h expected %h", i, p1(i), 32'h0);
      end
    end
    checks++;
    if (p2(0) !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL r0_unprotected: got %h expected %h", p2(0), 32'hFFFFFFFF);
    end
    $display("test_zero_reg: done");
  endtask

  task automatic test_exc_priority;
    @(negedge clk);
    set_all_addr(5'd3);
    wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'hAA;
    excValid = 1'b1; excPc = 32'h400; excAddr = 32'h1000;
    #1;
    checks++;
    if (p1(1) !== 32'h0) begin
      errors++; $display("FAIL exc_no_bypass: got %h expected %h", p1(1), 32'h0);
    end
    @(posedge clk); #1;
    wrEn = 1'b0; excValid = 1'b0;
    #1;
    checks++;
    if (p1(1) !== 32'h0) begin
      errors++; $display("FAIL exc_r3_unchanged: got %h expected %h", p1(1), 32'h0);
    end
    checks++;
    if (p2(1) !== 32'h0) begin
      errors++; $display("FAIL exc_r3_unchanged_dut2: got %h expected %h", p2(1), 32'h0);
    end
    checks++;
    if (rmValid !== 1'b1) begin
      errors++; $display("FAIL exc_rm_valid: got %b expected 1", rmValid);
    end
    checks++;
    if (rmOverflow !== 1'b0) begin
      errors++; $display("FAIL exc_no_overflow: got %b expected 0", rmOverflow);
    end
    moveRm = 1'b1; rmSel = 1'b0; rmSel2 = 2'd2;
    #1;
    checks++;
    if (p1(0) !== 32'h400) begin
      errors++; $display("FAIL exc_rm0: got %h expected %h", p1(0), 32'h400);
    end
    checks++;
    if (p2(0) !== 32'h0) begin
      errors++; $display("FAIL exc_rm_reserved: got %h expected %h", p2(0), 32'h0);
    end
    rmSel = 1'b1; rmSel2 = 2'd1;
    #1;
    checks++;
    if (p1(0) !== 32'h1000) begin
      errors++; $display("FAIL exc_rm1: got %h expected %h", p1(0), 32'h1000);
    end
    checks++;
    if (p2(0) !== 32'h1000) begin
      errors++; $display("FAIL exc_rm1_dut2: got %h expected %h", p2(0), 32'h1000);
    end
    moveRm = 1'b0;
    $display("test_exc_priority: done");
  endtask

  task automatic test_overflow_ack;
    @(negedge clk);
    excValid = 1'b1; excPc = 32'h500; excAddr = 32'h2000; rmAck = 1'b1;
    @(posedge clk); #1;
    excValid = 1'b0; rmAck = 1'b0; moveRm = 1'b1; rmSel = 1'b0;
    #1;
    checks++;
    if (rmValid !== 1'b1) begin
      errors++; $display("FAIL ovf_rm_valid: got %b expected 1", rmValid);
    end
    checks++;
    if (rmOverflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", rmOverflow);
    end
    checks++;
    if (p1(0) !== 32'h500) begin
      errors++; $display("FAIL ovf_rm0: got %h expected %h", p1(0), 32'h500);
    end
    @(negedge clk);
    rmAck = 1'b1;
    @(posedge clk); #1;
    #1;
    checks++;
    if (rmValid !== 1'b0) begin
      errors++; $display("FAIL ack_rm_valid: got %b expected 0", rmValid);
    end
    checks++;
    if (rmOverflow !== 1'b1) begin
      errors++; $display("FAIL ack_overflow_sticky: got %b expected 1", rmOverflow);
    end
    checks++;
    if (p1(0) !== 32'h500) begin
      errors++; $display("FAIL ack_rm0_retained: got %h expected %h", p1(0), 32'h500);
    end
    @(posedge clk); #1;
    rmAck = 1'b0;
    checks++;
    if (rmValid !== 1'b0) begin
      errors++; $display("FAIL ack_idle_ignored: got %b expected 0", rmValid);
    end
    moveRm = 1'b0;
    $display("test_overflow_ack: done");
  endtask

  task automatic test_multiport;
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      wrEn = 1'b1; wrAddr = 5'(r); wrData = 32'(r);
      @(posedge clk); #1;
      wrEn = 1'b0;
    end
    for (int i = 0; i < 4; i++) rdAddr[i*5 +: 5] = 5'(i + 1);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p1(i) !== 32'(i + 1)) begin
        errors++; $display("FAIL multi_distinct_p%0d: got %h expected %h", i, p1(i), 32'(i + 1));
      end
    end
    set_all_addr(5'd2);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p1(i) !== 32'h2) begin
        errors++; $display("FAIL multi_same_p%0d: got %h expected %h", i, p1(i), 32'h2);
      end
    end
    @(negedge clk);
    excValid = 1'b1; excPc = 32'h600; excAddr = 32'h3000;
    @(posedge clk); #1;
    excValid = 1'b0;
    wrEn = 1'b1; wrAddr = 5'd1; wrData = 32'h99;
    for (int i = 0; i < 4; i++) rdAddr[i*5 +: 5] = 5'(i + 1);
    #2;
    reset = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (p1(i) !== 32'h0) begin
        errors++; $display("FAIL midreset_p%0d: got %h expected %h", i, p1(i), 32'h0);
      end
    end
    checks++;
    if (rmValid !== 1'b0) begin
      errors++; $display("FAIL midreset_rm_valid: got %b expected 0", rmValid);
    end
    checks++;
    if (rmOverflow !== 1'b0) begin
      errors++; $display("FAIL midreset_overflow: got %b expected 0", rmOverflow);
    end
    @(negedge clk);
    reset = 1'b0; wrEn = 1'b0;
    #1;
    checks++;
    if (p1(0) !== 32'h0) begin
      errors++; $display("FAIL midreset_no_partial_write: got %h expected %h", p1(0), 32'h0);
    end
    checks++;
    if (p1(3) !== 32'h0) begin
      errors++; $display("FAIL midreset_r4_cleared: got %h expected %h", p1(3), 32'h0);
    end
    $display("test_multiport: done");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rdAddr = '0;
    rdAddr2 = '0;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_exc_priority();
    test_overflow_ack();
    test_multiport();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
